// File: rtl/glue_target_if.sv
// rtl/glue_target_if.sv - glue-to-target bus: select, bus word, ready pair and bank read data
interface glue_target_if;
  logic [1:0] sel;
  logic [8:0] data;
  logic [1:0] trdy;
  logic [7:0] dataout1;
  logic [7:0] dataout2;
  logic       busy;
  logic       sel_err;

  modport master (
    output sel, data,
    input  trdy, dataout1, dataout2, busy, sel_err
  );

  modport slave (
    input  sel, data,
    output trdy, dataout1, dataout2, busy, sel_err
  );
endinterface

// File: rtl/glue_target.sv
// rtl/glue_target.sv - dual-bank target stage: decode, direction sample, fixed-length burst, release
module glue_target #(
  parameter int DEPTH      = 16,
  parameter int DECODE_CYC = 3,
  parameter int DIR_DLY    = 3,
  parameter int BURST_LEN  = 7
) (
  input  logic         clk,
  input  logic         reset,
  glue_target_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DECODE_CYC + DIR_DLY + BURST_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    DIR,
    BURST,
    RELEASE
  } state_t;

  state_t         state_q, state_d;
  logic           bank_a_q, bank_a_d;
  logic           wr_q, wr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  ptr_a_q, ptr_a_d;
  logic [AW-1:0]  ptr_b_q, ptr_b_d;
  logic [1:0]     trdy_q, trdy_d;
  logic [7:0]     dout1_q, dout1_d;
  logic [7:0]     dout2_q, dout2_d;
  logic           busy_q, busy_d;
  logic           sel_err_q, sel_err_d;

  logic [7:0]     mem_a [DEPTH];
  logic [7:0]     mem_b [DEPTH];

  logic           beat_en;
  logic           beat_wr;
  logic           we_a;
  logic           we_b;

  always_comb begin
    state_d   = state_q;
    bank_a_d  = bank_a_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    ptr_a_d   = ptr_a_q;
    ptr_b_d   = ptr_b_q;
    trdy_d    = trdy_q;
    dout1_d   = dout1_q;
    dout2_d   = dout2_q;
    sel_err_d = 1'b0;
    beat_en   = 1'b0;
    beat_wr   = wr_q;
    we_a      = 1'b0;
    we_b      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.sel == 2'b10 || bus.sel == 2'b01) begin
          bank_a_d = bus.sel[1];
          cnt_d    = '0;
          state_d  = DECODE;
        end else if (bus.sel == 2'b11) begin
          sel_err_d = 1'b1;
        end
      end
      DECODE: begin
        if (cnt_q == CW'(DECODE_CYC - 1)) begin
          trdy_d  = bank_a_q ? 2'b01 : 2'b10;
          cnt_d   = '0;
          state_d = DIR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DIR: begin
        if (cnt_q == CW'(DIR_DLY - 1)) begin
          // Direction is latched and the first beat taken on the same edge.
          wr_d    = bus.data[8];
          beat_wr = bus.data[8];
          beat_en = 1'b1;
          cnt_d   = CW'(1);
          state_d = BURST;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BURST: begin
        if (cnt_q == CW'(BURST_LEN)) begin
          trdy_d  = 2'b11;
          dout1_d = 8'h00;
          dout2_d = 8'h00;
          state_d = RELEASE;
        end else begin
          beat_en = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        // Wait for the glue to drop its select so a held select cannot retrigger.
        if (bus.sel == 2'b00) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (beat_en) begin
      if (bank_a_q) begin
        if (beat_wr) we_a = 1'b1;
        else         dout1_d = mem_a[ptr_a_q];
        ptr_a_d = ptr_a_q + AW'(1);
      end else begin
        if (beat_wr) we_b = 1'b1;
        else         dout2_d = mem_b[ptr_b_q];
        ptr_b_d = ptr_b_q + AW'(1);
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bank_a_q  <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      ptr_a_q   <= '0;
      ptr_b_q   <= '0;
      trdy_q    <= 2'b11;
      dout1_q   <= 8'h00;
      dout2_q   <= 8'h00;
      busy_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_a_q  <= bank_a_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      ptr_a_q   <= ptr_a_d;
      ptr_b_q   <= ptr_b_d;
      trdy_q    <= trdy_d;
      dout1_q   <= dout1_d;
      dout2_q   <= dout2_d;
      busy_q    <= busy_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Storage is not reset, but a reset edge must suppress any pending write.
  always_ff @(posedge clk) begin
    if (!reset && we_a) mem_a[ptr_a_q] <= bus.data[7:0];
    if (!reset && we_b) mem_b[ptr_b_q] <= bus.data[7:0];
  end

  assign bus.trdy     = trdy_q;
  assign bus.dataout1 = dout1_q;
  assign bus.dataout2 = dout2_q;
  assign bus.busy     = busy_q;
  assign bus.sel_err  = sel_err_q;
endmodule

// File: doc/glue_target.md
Name: glue_target

Overview:
- Dual-bank target stage directly downstream of the bus glue/arbiter.
- Consumes the glue's target select `sel[1:0]` and muxed bus word `data[8:0]`; bit 8 is the write flag, bits 7:0 are payload.
- Produces the active-low target-ready pair `trdy[1:0]` and the per-bank read buses `dataout1` and `dataout2` that the glue muxes back onto `datao`.
- Each bank is a small register-file memory with its own wrapping address pointer; one burst is serviced at a time.

Parameters:
- DEPTH, 16, words per bank (power of 2, ≥2).
- DECODE_CYC, 3, edges from sel capture to trdy falling.
- DIR_DLY, 3, edges from trdy falling to data[8] direction sample.
- BURST_LEN, 7, data beats per transaction (≥1).

Ports:
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- sel, in, 2, target select from glue: 2'b10 = bank A, 2'b01 = bank B, 2'b00 = idle, 2'b11 = illegal.
- data, in, 9, bus word; [8] = 1 write, 0 read; [7:0] = write payload.
- trdy, out, 2, active-low ready: [1] = bank A, [0] = bank B.
- dataout1, out, 8, bank A read data.
- dataout2, out, 8, bank B read data.
- busy, out, 1, high in any state other than IDLE.
- sel_err, out, 1, one-cycle pulse when sel == 2'b11 is sampled in IDLE.

Behaviour:
- All outputs are registered.
- Reset value of every output: trdy = 2'b11, dataout1 = dataout2 = 8'h00, busy = 0, sel_err = 0.
- Reset also clears the state to IDLE, both address pointers to 0 and all counters.
- Memory contents are not reset.
- Reset asserted mid-burst aborts at the next edge; no further memory write occurs.

State machine: IDLE → DECODE → DIR → BURST → RELEASE → IDLE.
- IDLE:
  - sel == 2'b10 or 2'b01 at edge T0: latch the bank, go to DECODE, busy = 1.
  - sel == 2'b11: stay in IDLE, pulse sel_err.
  - sel == 2'b00: stay in IDLE.
- DECODE:
  - The selected trdy bit goes low at edge T0+DECODE_CYC; go to DIR.
  - The unselected trdy bit stays 1 throughout.
- DIR:
  - At edge T0+DECODE_CYC+DIR_DLY, sample data[8] to latch the direction; go to BURST.
  - On this same edge the first beat is taken: write stores data[7:0]; read loads dataout.
- BURST: BURST_LEN beats total, one per edge, including the DIR-edge beat.
  - Write: mem[bank][ptr] <= data[7:0], ptr <= ptr+1.
  - Read: the selected bank's dataout <= mem[bank][ptr], ptr <= ptr+1. The value holds until the next beat or RELEASE.
  - The unselected dataout holds 8'h00.
  - On the edge after the last beat: trdy → 2'b11, the active dataout → 8'h00, go to RELEASE.
- RELEASE: stay until sel == 2'b00 is sampled, then IDLE with busy = 0. This prevents a held select from retriggering.
- sel and data[8] changes after capture are ignored until RELEASE.
- Pointers:
  - Each bank's ptr persists across transactions.
  - ptr wraps DEPTH-1 → 0 without error.
  - Bank A and bank B pointers are independent.
- Read-after-write within the same bank returns the written value; writes are visible on the next edge.
- data[7:0] is don't-care on read beats; data[8] is examined only at the DIR edge.

Test Plan:
- Reset, then sel = 2'b10 at T0, data[8] = 1, payload 8'h11..8'h17 on beats → trdy = 2'b01 from T0+3 through the last beat (7 beats), then 2'b11; bank A mem[0..6] = 11..17; ptrA = 7.
- Continue: sel = 00, then sel = 10, data[8] = 0 → dataout1 presents mem[7], mem[8], ... for 7 beats; dataout2 stays 00; trdy[0] stays 1 throughout.
- Bank B: write 3 bursts of 7 beats (21 words) with DEPTH = 16 → ptrB wraps to 5; a subsequent read returns the words written at addresses 5..11, confirming overwrite at addresses 0..4.
- sel = 2'b11 while IDLE → sel_err pulses for 1 cycle, trdy stays 11, busy stays 0.
- Hold sel = 2'b10 across burst end → stays in RELEASE with trdy = 11; no second burst until sel = 00 is seen.
- Assert reset at beat 3 of a bank A write → next edge: trdy = 11, busy = 0, ptrA = 0; mem[3] holds the beat-3 data only if reset was sampled after that beat.
